cla_pipe_adder: RTL and testbench

//  Parametrised WIDTH-bit carry-lookahead add/subtract unit with a 2-stage pipeline and valid/ready handshake.

---
 rtl/cla_pipe_adder.sv | 129 ++++++++++++
 tb/tb_cla_pipe_adder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Two-stage carry-lookahead add/subtract unit built from 4-bit lookahead groups.
// Stage 1 registers bit and group propagate/generate; stage 2 resolves carries and flags.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NG = WIDTH / GROUP;

  if (GROUP != 4 || (WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_param_check
    $error("cla_pipe_adder: GROUP must be 4 and WIDTH a multiple of 4 within 4..64");
  end

  logic [WIDTH-1:0]     bb;
  logic [WIDTH-1:0]     p_d;
  logic [WIDTH-1:0]     g_d;
  logic [NG-1:0][2:0]   g3_d;
  logic [NG-1:0]        gp_d;
  logic [NG-1:0]        gg_d;
  logic                 c0_d;

  logic [WIDTH-1:0]     p_q;
  logic [NG-1:0][2:0]   g_q;
  logic [NG-1:0]        gp_q;
  logic [NG-1:0]        gg_q;
  logic                 c0_q;
  logic                 s1_valid;

  logic                 stall;
  logic [NG:0]          gc;
  logic [WIDTH-1:0]     c;
  logic [WIDTH-1:0]     sum_d;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall | ~s1_valid;

  always_comb begin
    bb   = sub ? ~b : b;
    c0_d = sub | cin;
    p_d  = a ^ bb;
    g_d  = a & bb;
    gp_d = '0;
    gg_d = '0;
    g3_d = '0;
    for (int k = 0; k < NG; k++) begin
      gp_d[k] = &p_d[4*k +: 4];
      gg_d[k] = g_d[4*k+3]
              | (p_d[4*k+3] & g_d[4*k+2])
              | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
              | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
      // The top generate bit of each group only feeds the group generate.
      g3_d[k] = g_d[4*k +: 3];
    end
  end

  // Stage 1 loads on advance and also when it holds a bubble under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      p_q      <= '0;
      g_q      <= '0;
      gp_q     <= '0;
      gg_q     <= '0;
      c0_q     <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        p_q  <= p_d;
        g_q  <= g3_d;
        gp_q <= gp_d;
        gg_q <= gg_d;
        c0_q <= c0_d;
      end
    end
  end

  always_comb begin
    gc    = '0;
    c     = '0;
    gc[0] = c0_q;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gg_q[k] | (gp_q[k] & gc[k]);
    end
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g_q[k][0] | (p_q[4*k] & gc[k]);
      c[4*k+2] = g_q[k][1] | (p_q[4*k+1] & g_q[k][0])
               | (p_q[4*k+1] & p_q[4*k] & gc[k]);
      c[4*k+3] = g_q[k][2] | (p_q[4*k+2] & g_q[k][1])
               | (p_q[4*k+2] & p_q[4*k+1] & g_q[k][0])
               | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k] & gc[k]);
    end
    sum_d = p_q ^ c;
  end

  // Result registers only change on an accepted advance of a valid stage-1 entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_d;
        cout <= gc[NG];
        ovf  <= c[WIDTH-1] ^ gc[NG];
        zero <= ~|sum_d;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed cases at W=16 plus randomized traffic on W=8/16/32/64
// instances sharing one stimulus stream, checked against an arithmetic model with per-width queues.
module tb_cla_pipe_adder;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cin, sub;
  logic [63:0] a_drv, b_drv;

  logic        ir_arr[4], ov_arr[4], co_arr[4], of_arr[4], z_arr[4];
  logic [63:0] sum_arr[4];
  int          widths[4] = '{8, 16, 32, 64};

  int          n_checks = 0;
  int          n_fail = 0;

  logic [63:0] qa[4][8], qb[4][8];
  logic        qc[4][8], qs[4][8];
  int          wp[4] = '{0, 0, 0, 0};
  int          rp[4] = '{0, 0, 0, 0};
  logic        prev_stall[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [66:0] held[4];
  logic        last_acc = 1'b0;

  logic [15:0] t4a[4] = '{16'h0001, 16'h1000, 16'hFFFF, 16'h8000};
  logic [15:0] t4b[4] = '{16'h0002, 16'h0FFF, 16'hFFFF, 16'h8000};
  logic [18:0] t4exp[4] = '{{3'b000, 16'h0003}, {3'b000, 16'h1FFF},
                            {3'b100, 16'hFFFE}, {3'b111, 16'h0000}};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int W = 8 << gi;
    logic [W-1:0] sum_w;
    logic         ir, ov, co, of, z;
    cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir),
      .a(a_drv[W-1:0]), .b(b_drv[W-1:0]), .cin(cin), .sub(sub),
      .out_valid(ov), .out_ready(out_ready), .sum(sum_w),
      .cout(co), .ovf(of), .zero(z)
    );
    assign sum_arr[gi] = 64'(sum_w);
    assign ir_arr[gi]  = ir;
    assign ov_arr[gi]  = ov;
    assign co_arr[gi]  = co;
    assign of_arr[gi]  = of;
    assign z_arr[gi]   = z;
  end

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {cout, ovf, zero, sum} for a w-bit operation using plain integer arithmetic.
  function automatic logic [66:0] model(int w, logic [63:0] a, logic [63:0] b, logic ci, logic sb);
    logic [64:0]        mask, aa, bv, full;
    logic signed [66:0] sa, sbv, ss, lim;
    logic               c0;
    logic [63:0]        s;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bv   = (sb ? ~{1'b0, b} : {1'b0, b}) & mask;
    c0   = sb ? 1'b1 : ci;
    full = aa + bv + {64'd0, c0};
    s    = full[63:0] & mask[63:0];
    sa   = $signed({2'b00, aa});
    if (aa[w-1]) sa = sa - $signed({2'b00, mask}) - 67'sd1;
    sbv  = $signed({2'b00, bv});
    if (bv[w-1]) sbv = sbv - $signed({2'b00, mask}) - 67'sd1;
    ss   = sa + sbv + $signed({66'd0, c0});
    lim  = $signed(67'd1 << (w - 1));
    return {full[w], (ss >= lim) || (ss < -lim), s == 64'd0, s};
  endfunction

  task automatic monitor();
    for (int i = 0; i < 4; i++) begin
      int          cnt, j;
      logic [66:0] act;
      string       sfx;
      sfx = $sformatf("_w%0d", widths[i]);
      cnt = wp[i] - rp[i];
      act = {co_arr[i], of_arr[i], z_arr[i], sum_arr[i]};
      if (rst) begin
        wp[i] = 0;
        rp[i] = 0;
        prev_stall[i] = 1'b0;
      end else begin
        check({"in_ready", sfx}, 128'(ir_arr[i]), 128'(out_ready | (cnt < 2)));
        if (prev_stall[i])
          check({"hold", sfx}, 128'({ov_arr[i], act}), 128'({1'b1, held[i]}));
        if (ov_arr[i])
          check({"occupancy", sfx}, 128'(cnt > 0), 128'(1));
        if (ov_arr[i] && out_ready && cnt > 0) begin
          j = rp[i] % 8;
          check({"result", sfx}, 128'(act),
                128'(model(widths[i], qa[i][j], qb[i][j], qc[i][j], qs[i][j])));
          rp[i]++;
        end
        prev_stall[i] = ov_arr[i] & ~out_ready;
        held[i] = act;
        if (in_valid && ir_arr[i]) begin
          j = wp[i] % 8;
          qa[i][j] = a_drv;
          qb[i][j] = b_drv;
          qc[i][j] = cin;
          qs[i][j] = sub;
          wp[i]++;
        end
      end
    end
    last_acc = in_valid & ir_arr[1];
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(string tag, logic [15:0] a, logic [15:0] b, logic ci, logic sb,
                          logic [18:0] exp);
    a_drv = 64'(a);
    b_drv = 64'(b);
    cin = ci;
    sub = sb;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 128'(ov_arr[1]), 128'(0));
    tick();
    check(tag, 128'({ov_arr[1], co_arr[1], of_arr[1], z_arr[1], sum_arr[1][15:0]}),
          128'({1'b1, exp}));
    tick();
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(7))
      0:       return 64'd0;
      1:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, got, n_ops;
    logic saw_block, acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_drv = '0; b_drv = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_w%0d", widths[i]),
            128'({ov_arr[i], co_arr[i], of_arr[i], z_arr[i], sum_arr[i], ir_arr[i]}),
            128'({68'd0, 1'b1}));

    directed("t1_add",      16'h1234, 16'h4321, 1'b0, 1'b0, {3'b000, 16'h5555});
    directed("t2_wrap",     16'hFFFF, 16'h0000, 1'b1, 1'b0, {3'b101, 16'h0000});
    directed("t3_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, {3'b010, 16'h8000});
    directed("t3_sub",      16'h0005, 16'h0007, 1'b0, 1'b1, {3'b000, 16'hFFFE});
    directed("sub_cin_ign", 16'h0010, 16'h0010, 1'b1, 1'b1, {3'b101, 16'h0000});

    k = 0; got = 0; saw_block = 1'b0;
    cin = 1'b0; sub = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      in_valid  = (k < 4);
      a_drv     = 64'(t4a[(k < 4) ? k : 3]);
      b_drv     = 64'(t4b[(k < 4) ? k : 3]);
      out_ready = !(c >= 2 && c < 5);
      #1;
      if (ov_arr[1] && out_ready) begin
        check($sformatf("t4_order%0d", got),
              128'({co_arr[1], of_arr[1], z_arr[1], sum_arr[1][15:0]}), 128'(t4exp[got]));
        got++;
      end
      if (!ir_arr[1]) saw_block = 1'b1;
      acc = in_valid && ir_arr[1];
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("t4_all_delivered", 128'(got), 128'(4));
    check("t4_in_ready_low", 128'(saw_block), 128'(1));
    tick();

    a_drv = 64'h1111; b_drv = 64'h2222; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    a_drv = 64'h0F0F; b_drv = 64'h0101;
    tick();
    check("t5_inflight", 128'({ov_arr[1], sum_arr[1][15:0]}), 128'({1'b1, 16'h3333}));
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("t5_flush", 128'({ov_arr[1], co_arr[1], of_arr[1], z_arr[1], sum_arr[1]}), 128'(0));
    tick();
    tick();
    check("t5_no_stale", 128'(ov_arr[1]), 128'(0));
    directed("t5_after", 16'h0102, 16'h0304, 1'b0, 1'b0, {3'b000, 16'h0406});

    n_ops = 0;
    in_valid = 1'b0;
    last_acc = 1'b0;
    for (int c = 0; c < 30000 && n_ops < 10000; c++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(3) != 0);
        a_drv = pick();
        b_drv = pick();
        cin = 1'($urandom_range(1));
        sub = 1'($urandom_range(1));
      end
      out_ready = ($urandom_range(3) != 0);
      tick();
      if (last_acc) n_ops++;
    end
    check("t6_op_count", 128'(n_ops >= 10000), 128'(1));

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    for (int i = 0; i < 4; i++)
      check($sformatf("drain_w%0d", widths[i]), 128'(wp[i] - rp[i]), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
